c432_key_loader: RTL

C432_KEY_LOADER -- requirements
Module: c432_key_loader

---
 rtl/c432_key_pkg.sv | 14 +
 rtl/key_shadow_sr.sv | 64 ++++++
 rtl/c432_key_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/c432_key_pkg.sv
// Shared definitions for the c432 key loader.
//   KEY_W_DEFAULT : default number of key inputs (s_0..s_11) on the locked c432
//   key_state_e   : loader FSM state encoding
package c432_key_pkg;

    localparam int unsigned KEY_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } key_state_e;

endpackage

// File: rtl/key_shadow_sr.sv
// Shadow shift register for the c432 key loader, with running parity and bit counter.
// Holds the key being loaded until the FSM commits it, so the locked circuit never
// sees a partially shifted key.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   clr      : zero shadow, parity and count
//   shift_en : accept din into the next LSB-first position
//   din      : serial key bit
//   shadow   : accumulated key bits, shadow[n] = n-th accepted bit
//   par      : XOR of all accepted bits
//   cnt      : number of accepted bits, saturates at KEY_W
module key_shadow_sr
    import c432_key_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEFAULT,
    localparam int unsigned CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [KEY_W-1:0] shadow,
    output logic             par,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

    logic [KEY_W-1:0] shadow_d;
    logic             par_d;
    logic [CNT_W-1:0] cnt_d;

    // Bits enter at the MSB and move down, so after KEY_W shifts the first bit
    // sits at position 0. Shifting stops once full so the count never wraps.
    always_comb begin
        shadow_d = shadow;
        par_d    = par;
        cnt_d    = cnt;
        if (clr) begin
            shadow_d = '0;
            par_d    = 1'b0;
            cnt_d    = '0;
        end else if (shift_en && (cnt != CNT_FULL)) begin
            shadow_d            = shadow >> 1;
            shadow_d[KEY_W-1]   = din;
            par_d               = par ^ din;
            cnt_d               = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            par    <= 1'b0;
            cnt    <= '0;
        end else begin
            shadow <= shadow_d;
            par    <= par_d;
            cnt    <= cnt_d;
        end
    end

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for a logic-locked c432.
// Receives KEY_W key bits LSB first followed by one parity bit, and commits the
// key atomically only when the parity bit matches.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : begin a load (ignored while busy)
//   abort     : discard the load in progress
//   bit_valid : serial bit present
//   bit_data  : serial bit (key LSB first, then parity)
//   bit_ready : loader accepts bit_data this cycle
//   key       : committed key, key[i] drives s_i
//   key_valid : key holds a committed value
//   busy      : load in progress
//   err       : last load failed its parity check
module c432_key_loader
    import c432_key_pkg::*;
#(
    parameter int unsigned KEY_W   = KEY_W_DEFAULT,
    parameter bit          PAR_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int unsigned      CNT_W    = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

    key_state_e       state;
    key_state_e       state_d;
    logic             clr;
    logic             shift_en;
    logic             xfer;
    logic [KEY_W-1:0] shadow;
    logic             par;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key_d;
    logic             key_valid_d;
    logic             err_d;

    key_shadow_sr #(
        .KEY_W (KEY_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .din      (bit_data),
        .shadow   (shadow),
        .par      (par),
        .cnt      (cnt)
    );

    assign busy = (state != StIdle);
    // Ready drops under abort/rst so a sender never sees an overridden bit as taken.
    assign bit_ready = busy && !abort && !rst;
    assign xfer      = bit_valid && bit_ready;

    always_comb begin
        state_d     = state;
        clr         = 1'b0;
        shift_en    = 1'b0;
        key_d       = key;
        key_valid_d = key_valid;
        err_d       = err;
        case (state)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    clr     = 1'b1;
                    err_d   = 1'b0;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (xfer) begin
                    shift_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (abort) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (xfer) begin
                    state_d = StIdle;
                    if (bit_data == (par ^ PAR_ODD)) begin
                        key_d       = shadow;
                        key_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            key       <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            key       <= key_d;
            key_valid <= key_valid_d;
            err       <= err_d;
        end
    end

endmodule
